fpu_issue_arbiter: RTL and testbench

- Shares the single half-precision FPU (two-register-stage, fixed-latency) between two requesters: the scalar core (sfpu ops) and the vector element sequencer (vfpu ops).
- Performs round-robin arbitration with vector burst locking, and drives the FPU `_w` inputs.
- Tracks in-flight ops in a tag pipeline and routes each result and S_Flags back to the requester that issued it.
- Keeps a sticky fflags accumulator per requester.

---
 rtl/fpu_issue_arbiter.sv | 241 ++++++++++++++++++++++++
 tb/tb_fpu_issue_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_issue_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fpu_issue_arbiter
// Description : Shares one fixed-latency half-precision FPU between the scalar
//               core and the vector element sequencer. Round-robin arbitration
//               with vector burst locking, FPU issue mux, in-flight tag
//               pipeline for response routing, and per-requester sticky
//               fflags accumulators.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_issue_arbiter #(
    parameter int STD = 15,
    parameter int LAT = 2
) (
    input  logic              clk,
    input  logic              rst,

    // Scalar requester
    input  logic              s_req_valid,
    output logic              s_req_ready,
    input  logic [STD:0]      s_opa,
    input  logic [STD:0]      s_opb,
    input  logic [STD:0]      s_opc,
    input  logic [31:0]       s_int,
    input  logic [2:0]        s_frm,
    input  logic [23:0]       s_sfpu_op,

    // Vector requester
    input  logic              v_req_valid,
    output logic              v_req_ready,
    input  logic              v_last,
    input  logic [STD:0]      v_opa,
    input  logic [STD:0]      v_opb,
    input  logic [STD:0]      v_opc,
    input  logic [31:0]       v_int,
    input  logic [2:0]        v_frm,
    input  logic [27:0]       v_vfpu_op,

    // FPU issue side
    output logic [STD:0]      fpu_opa_w,
    output logic [STD:0]      fpu_opb_w,
    output logic [STD:0]      fpu_opc_w,
    output logic [31:0]       fpu_int_w,
    output logic [2:0]        fpu_frm_w,
    output logic [23:0]       fpu_sfpu_op_w,
    output logic [27:0]       fpu_vfpu_op_w,
    output logic [2:0]        fpu_sel_w,

    // FPU result side
    input  logic [STD:0]      fpu_resultant,
    input  logic [31:0]       fpu_result_rd,
    input  logic [4:0]        fpu_s_flags,

    // Scalar response
    output logic              s_rsp_valid,
    output logic [STD:0]      s_rsp_result,
    output logic [31:0]       s_rsp_rd,
    output logic [4:0]        s_rsp_flags,

    // Vector response
    output logic              v_rsp_valid,
    output logic [STD:0]      v_rsp_result,
    output logic [31:0]       v_rsp_rd,
    output logic [4:0]        v_rsp_flags,

    // Sticky flags
    output logic [4:0]        s_fflags,
    input  logic              s_fflags_clr,
    output logic [4:0]        v_fflags,
    input  logic              v_fflags_clr,

    output logic              busy
);

    // Owner encoding shared by the priority pointer and the tag pipeline
    localparam logic c_owner_scalar = 1'b0;
    localparam logic c_owner_vector = 1'b1;

    // ------------------------------------------------------------------------
    // Arbitration state
    // ------------------------------------------------------------------------
    logic r_prio;   // requester that wins the next contended cycle
    logic r_lock;   // vector burst in progress, scalar locked out

    logic w_grant_s;
    logic w_grant_v;
    logic w_issue_valid;
    logic w_issue_owner;

    // Pick at most one winner: lock forces vector, otherwise round-robin on contention
    always_comb begin
        w_grant_s = s_req_valid && !r_lock &&
                    (!v_req_valid || (r_prio == c_owner_scalar));
        w_grant_v = v_req_valid &&
                    (r_lock || !s_req_valid || (r_prio == c_owner_vector));
    end

    assign s_req_ready   = w_grant_s;
    assign v_req_ready   = w_grant_v;
    assign w_issue_valid = w_grant_s || w_grant_v;
    assign w_issue_owner = w_grant_v ? c_owner_vector : c_owner_scalar;

    // Advance round-robin pointer and burst lock on each accepted request.
    // Mid-burst vector beats leave the pointer alone; the closing beat hands
    // priority back to the scalar side.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prio <= c_owner_scalar;
            r_lock <= 1'b0;
        end else if (w_grant_s) begin
            r_prio <= c_owner_vector;
        end else if (w_grant_v) begin
            r_lock <= !v_last;
            if (v_last) begin
                r_prio <= c_owner_scalar;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Issue mux: winner's payload to the FPU, zeros when idle so the FPU
    // computes a harmless zero result.
    // ------------------------------------------------------------------------
    // Steer the granted payload onto the FPU input wires
    always_comb begin
        fpu_opa_w     = '0;
        fpu_opb_w     = '0;
        fpu_opc_w     = '0;
        fpu_int_w     = '0;
        fpu_frm_w     = '0;
        fpu_sfpu_op_w = '0;
        fpu_vfpu_op_w = '0;
        if (w_grant_s) begin
            fpu_opa_w     = s_opa;
            fpu_opb_w     = s_opb;
            fpu_opc_w     = s_opc;
            fpu_int_w     = s_int;
            fpu_frm_w     = s_frm;
            fpu_sfpu_op_w = s_sfpu_op;
        end else if (w_grant_v) begin
            fpu_opa_w     = v_opa;
            fpu_opb_w     = v_opb;
            fpu_opc_w     = v_opc;
            fpu_int_w     = v_int;
            fpu_frm_w     = v_frm;
            fpu_vfpu_op_w = v_vfpu_op;
        end
    end

    assign fpu_sel_w = 3'd0;

    // ------------------------------------------------------------------------
    // Tag pipeline: mirrors the FPU latency so the tail entry lines up with
    // the result the FPU presents for that op.
    // ------------------------------------------------------------------------
    logic [LAT-1:0] r_tag_valid;
    logic [LAT-1:0] r_tag_owner;

    generate
        if (LAT == 1) begin : g_tag_single
            // Single-stage latency: the grant lands directly in the tail
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_tag_valid <= '0;
                    r_tag_owner <= '0;
                end else begin
                    r_tag_valid <= w_issue_valid;
                    r_tag_owner <= w_issue_owner;
                end
            end
        end else begin : g_tag_shift
            // Shift grants toward the tail one stage per cycle
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_tag_valid <= '0;
                    r_tag_owner <= '0;
                end else begin
                    r_tag_valid <= {r_tag_valid[LAT-2:0], w_issue_valid};
                    r_tag_owner <= {r_tag_owner[LAT-2:0], w_issue_owner};
                end
            end
        end
    endgenerate

    logic w_tail_valid;
    logic w_tail_owner;

    assign w_tail_valid = r_tag_valid[LAT-1];
    assign w_tail_owner = r_tag_owner[LAT-1];
    assign busy         = |r_tag_valid;

    // ------------------------------------------------------------------------
    // Response routing: the tail owner gets the FPU outputs, the other side
    // sees zeros.
    // ------------------------------------------------------------------------
    // Route the retiring result to the requester that issued it
    always_comb begin
        s_rsp_valid  = w_tail_valid && (w_tail_owner == c_owner_scalar);
        v_rsp_valid  = w_tail_valid && (w_tail_owner == c_owner_vector);
        s_rsp_result = s_rsp_valid ? fpu_resultant : '0;
        s_rsp_rd     = s_rsp_valid ? fpu_result_rd : '0;
        s_rsp_flags  = s_rsp_valid ? fpu_s_flags   : '0;
        v_rsp_result = v_rsp_valid ? fpu_resultant : '0;
        v_rsp_rd     = v_rsp_valid ? fpu_result_rd : '0;
        v_rsp_flags  = v_rsp_valid ? fpu_s_flags   : '0;
    end

    // ------------------------------------------------------------------------
    // Sticky flag accumulators. A clear coinciding with a response drops the
    // old contents but keeps the new flags so no exception is lost.
    // ------------------------------------------------------------------------
    logic [4:0] r_s_fflags;
    logic [4:0] r_v_fflags;

    // Accumulate scalar flags, honouring clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s_fflags <= '0;
        end else if (s_rsp_valid) begin
            r_s_fflags <= (s_fflags_clr ? 5'd0 : r_s_fflags) | s_rsp_flags;
        end else if (s_fflags_clr) begin
            r_s_fflags <= '0;
        end
    end

    // Accumulate vector flags, honouring clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v_fflags <= '0;
        end else if (v_rsp_valid) begin
            r_v_fflags <= (v_fflags_clr ? 5'd0 : r_v_fflags) | v_rsp_flags;
        end else if (v_fflags_clr) begin
            r_v_fflags <= '0;
        end
    end

    assign s_fflags = r_s_fflags;
    assign v_fflags = r_v_fflags;

endmodule
`default_nettype wire

// File: tb/tb_fpu_issue_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpu_issue_arbiter
// Description : Directed self-checking bench for fpu_issue_arbiter with a
//               small two-stage FPU stand-in producing known results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_issue_arbiter;

    logic        clk;
    logic        rst;
    logic        s_req_valid, s_req_ready;
    logic [15:0] s_opa, s_opb, s_opc;
    logic [31:0] s_int;
    logic [2:0]  s_frm;
    logic [23:0] s_sfpu_op;
    logic        v_req_valid, v_req_ready, v_last;
    logic [15:0] v_opa, v_opb, v_opc;
    logic [31:0] v_int;
    logic [2:0]  v_frm;
    logic [27:0] v_vfpu_op;
    logic [15:0] fpu_opa_w, fpu_opb_w, fpu_opc_w;
    logic [31:0] fpu_int_w;
    logic [2:0]  fpu_frm_w;
    logic [23:0] fpu_sfpu_op_w;
    logic [27:0] fpu_vfpu_op_w;
    logic [2:0]  fpu_sel_w;
    logic [15:0] fpu_resultant;
    logic [31:0] fpu_result_rd;
    logic [4:0]  fpu_s_flags;
    logic        s_rsp_valid, v_rsp_valid;
    logic [15:0] s_rsp_result, v_rsp_result;
    logic [31:0] s_rsp_rd, v_rsp_rd;
    logic [4:0]  s_rsp_flags, v_rsp_flags;
    logic [4:0]  s_fflags, v_fflags;
    logic        s_fflags_clr, v_fflags_clr;
    logic        busy;

    int checks = 0;
    int errors = 0;

    fpu_issue_arbiter #(.STD(15), .LAT(2)) dut (
        .clk(clk), .rst(rst),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
        .s_opa(s_opa), .s_opb(s_opb), .s_opc(s_opc), .s_int(s_int),
        .s_frm(s_frm), .s_sfpu_op(s_sfpu_op),
        .v_req_valid(v_req_valid), .v_req_ready(v_req_ready), .v_last(v_last),
        .v_opa(v_opa), .v_opb(v_opb), .v_opc(v_opc), .v_int(v_int),
        .v_frm(v_frm), .v_vfpu_op(v_vfpu_op),
        .fpu_opa_w(fpu_opa_w), .fpu_opb_w(fpu_opb_w), .fpu_opc_w(fpu_opc_w),
        .fpu_int_w(fpu_int_w), .fpu_frm_w(fpu_frm_w),
        .fpu_sfpu_op_w(fpu_sfpu_op_w), .fpu_vfpu_op_w(fpu_vfpu_op_w),
        .fpu_sel_w(fpu_sel_w),
        .fpu_resultant(fpu_resultant), .fpu_result_rd(fpu_result_rd),
        .fpu_s_flags(fpu_s_flags),
        .s_rsp_valid(s_rsp_valid), .s_rsp_result(s_rsp_result),
        .s_rsp_rd(s_rsp_rd), .s_rsp_flags(s_rsp_flags),
        .v_rsp_valid(v_rsp_valid), .v_rsp_result(v_rsp_result),
        .v_rsp_rd(v_rsp_rd), .v_rsp_flags(v_rsp_flags),
        .s_fflags(s_fflags), .s_fflags_clr(s_fflags_clr),
        .v_fflags(v_fflags), .v_fflags_clr(v_fflags_clr),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // FPU stand-in: opcode bit 0 = add, bit 2 = sqrt (scalar), bit 3 = div.
    // 1.0+1.0 = 2.0, x/0 = +inf with DZ, sqrt(negative) = qNaN with NV,
    // anything else returns opa^opb. rd echoes the integer operand.
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic [15:0] res;
        logic [31:0] rd;
        logic [4:0]  flags;
    } fpu_out_t;

    function automatic fpu_out_t mock_fpu(input logic [23:0] sop, input logic [27:0] vop,
                                          input logic [15:0] a, input logic [15:0] b,
                                          input logic [31:0] iv);
        fpu_out_t o;
        o = '0;
        if (sop != 24'd0 || vop != 28'd0) begin
            o.rd = iv;
            if ((sop[3] || vop[3]) && b[14:0] == 15'd0) begin
                o.res   = 16'h7C00;
                o.flags = 5'b01000;
            end else if (sop[2] && a[15]) begin
                o.res   = 16'h7E00;
                o.flags = 5'b10000;
            end else if ((sop[0] || vop[0]) && a == 16'h3C00 && b == 16'h3C00) begin
                o.res = 16'h4000;
            end else begin
                o.res = a ^ b;
            end
        end
        return o;
    endfunction

    fpu_out_t st1, st2;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            st1 <= '0;
            st2 <= '0;
        end else begin
            st1 <= mock_fpu(fpu_sfpu_op_w, fpu_vfpu_op_w, fpu_opa_w, fpu_opb_w, fpu_int_w);
            st2 <= st1;
        end
    end

    assign fpu_resultant = st2.res;
    assign fpu_result_rd = st2.rd;
    assign fpu_s_flags   = st2.flags;

    // ------------------------------------------------------------------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        s_req_valid = 0; s_opa = 0; s_opb = 0; s_opc = 0; s_int = 0; s_frm = 0; s_sfpu_op = 0;
        v_req_valid = 0; v_last = 0; v_opa = 0; v_opb = 0; v_opc = 0; v_int = 0; v_frm = 0;
        v_vfpu_op = 0;
    endtask

    // Expected tables
    logic [15:0] alt_res [6] = '{16'h0, 16'h0, 16'h1001, 16'h2002, 16'h1000, 16'h2003};
    logic        bu_sr   [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        bu_vr   [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        bu_srsp [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        bu_vrsp [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        rst = 1'b1;
        s_fflags_clr = 0;
        v_fflags_clr = 0;
        idle();
        tick();
        tick();

        // ---------------- reset state ----------------
        chk("rst_busy", busy, 0);
        chk("rst_s_fflags", s_fflags, 0);
        chk("rst_v_fflags", v_fflags, 0);
        chk("rst_s_rsp_valid", s_rsp_valid, 0);
        chk("rst_v_rsp_valid", v_rsp_valid, 0);
        chk("rst_fpu_sel", fpu_sel_w, 0);
        rst = 1'b0;
        tick();

        // ---------------- scalar fadd 1.0 + 1.0 ----------------
        s_req_valid = 1; s_opa = 16'h3C00; s_opb = 16'h3C00; s_opc = 16'h1111;
        s_int = 32'h11; s_frm = 3'd2; s_sfpu_op = 24'h1;
        #1;
        chk("add_s_ready", s_req_ready, 1);
        chk("add_v_ready", v_req_ready, 0);
        chk("add_fpu_opa", fpu_opa_w, 16'h3C00);
        chk("add_fpu_opc", fpu_opc_w, 16'h1111);
        chk("add_fpu_frm", fpu_frm_w, 3'd2);
        chk("add_fpu_int", fpu_int_w, 32'h11);
        chk("add_fpu_sop", fpu_sfpu_op_w, 24'h1);
        chk("add_fpu_vop", fpu_vfpu_op_w, 0);
        tick();
        idle();
        #1;
        chk("idle_fpu_opa", fpu_opa_w, 0);
        chk("idle_fpu_sop", fpu_sfpu_op_w, 0);
        chk("idle_fpu_int", fpu_int_w, 0);
        chk("add_busy_t1", busy, 1);
        chk("add_no_rsp_t1", s_rsp_valid, 0);
        tick();
        chk("add_rsp_valid", s_rsp_valid, 1);
        chk("add_rsp_result", s_rsp_result, 16'h4000);
        chk("add_rsp_rd", s_rsp_rd, 32'h11);
        chk("add_rsp_flags", s_rsp_flags, 0);
        chk("add_v_rsp_quiet", v_rsp_valid, 0);
        chk("add_v_rsp_result0", v_rsp_result, 0);
        chk("add_busy_t2", busy, 1);
        tick();
        chk("add_busy_t3", busy, 0);
        chk("add_rsp_gone", s_rsp_valid, 0);
        chk("add_rsp_result_zero", s_rsp_result, 0);

        // ---------------- reset one cycle after a grant ----------------
        s_req_valid = 1; s_opa = 16'h1234; s_opb = 16'h0001; s_sfpu_op = 24'h1;
        #1;
        chk("rmid_s_ready", s_req_ready, 1);
        tick();
        idle();
        #1;
        chk("rmid_busy_pre", busy, 1);
        rst = 1'b1;
        #1;
        chk("rmid_busy_async", busy, 0);
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rmid_no_s_rsp", s_rsp_valid, 0);
            chk("rmid_no_v_rsp", v_rsp_valid, 0);
            chk("rmid_busy", busy, 0);
            tick();
        end
        chk("rmid_s_fflags", s_fflags, 0);

        // ---------------- alternating S/V with v_last=1 ----------------
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                s_req_valid = 1; s_opb = 16'h0001; s_sfpu_op = 24'h1; s_int = 32'hA;
                s_opa = (i < 2) ? 16'h1000 : 16'h1001;
                v_req_valid = 1; v_last = 1; v_opb = 16'h0002; v_vfpu_op = 28'h1; v_int = 32'hB;
                v_opa = (i < 2) ? 16'h2000 : 16'h2001;
            end else begin
                idle();
            end
            #1;
            if (i < 4) begin
                chk("alt_s_ready", s_req_ready, (i % 2) == 0);
                chk("alt_v_ready", v_req_ready, (i % 2) == 1);
            end
            if (i >= 2) begin
                chk("alt_s_rsp", s_rsp_valid, (i % 2) == 0);
                chk("alt_v_rsp", v_rsp_valid, (i % 2) == 1);
                if ((i % 2) == 0) chk("alt_s_res", s_rsp_result, alt_res[i]);
                else              chk("alt_v_res", v_rsp_result, alt_res[i]);
            end
            if (i == 3) chk("alt_v_rd", v_rsp_rd, 32'hB);
            tick();
        end

        // ---------------- 4-beat vector burst vs scalar ----------------
        for (int i = 0; i < 8; i++) begin
            if (i < 6) begin
                int beat;
                beat = (i == 0) ? 0 : i - 1;
                s_req_valid = 1; s_sfpu_op = 24'h1; s_opb = 16'h0001;
                s_opa = (i == 0) ? 16'h0500 : 16'h0501;
                v_req_valid = 1; v_vfpu_op = 28'h1; v_opb = 16'h0002;
                v_opa = 16'h3000 + 16'(beat);
                v_last = (i >= 4);
            end else begin
                idle();
            end
            #1;
            chk("bur_s_ready", s_req_ready, bu_sr[i]);
            chk("bur_v_ready", v_req_ready, bu_vr[i]);
            chk("bur_s_rsp", s_rsp_valid, bu_srsp[i]);
            chk("bur_v_rsp", v_rsp_valid, bu_vrsp[i]);
            if (i == 6) chk("bur_v_res_beat4", v_rsp_result, 16'h3001);
            tick();
        end

        // ---------------- sticky flags ----------------
        s_req_valid = 1; s_sfpu_op = 24'h4; s_opa = 16'hBC00; s_opb = 16'h0000;
        #1;
        chk("sqrt_s_ready", s_req_ready, 1);
        tick();
        idle();
        tick();
        chk("sqrt_rsp_flags", s_rsp_flags, 5'b10000);
        chk("sqrt_rsp_result", s_rsp_result, 16'h7E00);
        tick();
        chk("sqrt_s_fflags", s_fflags, 5'b10000);
        chk("sqrt_v_fflags", v_fflags, 0);

        s_req_valid = 1; s_sfpu_op = 24'h8; s_opa = 16'h3C00; s_opb = 16'h0000;
        #1;
        chk("div_s_ready", s_req_ready, 1);
        tick();
        idle();
        tick();
        s_fflags_clr = 1;
        #1;
        chk("div_rsp_flags", s_rsp_flags, 5'b01000);
        chk("div_rsp_result", s_rsp_result, 16'h7C00);
        tick();
        s_fflags_clr = 0;
        chk("div_clr_set_wins", s_fflags, 5'b01000);
        s_fflags_clr = 1;
        tick();
        s_fflags_clr = 0;
        chk("s_clr_alone", s_fflags, 0);

        v_req_valid = 1; v_last = 1; v_vfpu_op = 28'h8; v_opa = 16'h3C00; v_opb = 16'h0000;
        #1;
        chk("vdiv_v_ready", v_req_ready, 1);
        chk("vdiv_fpu_sop", fpu_sfpu_op_w, 0);
        chk("vdiv_fpu_vop", fpu_vfpu_op_w, 28'h8);
        tick();
        idle();
        tick();
        chk("vdiv_rsp_valid", v_rsp_valid, 1);
        chk("vdiv_rsp_flags", v_rsp_flags, 5'b01000);
        chk("vdiv_s_quiet", s_rsp_valid, 0);
        tick();
        chk("vdiv_v_fflags", v_fflags, 5'b01000);
        chk("vdiv_s_fflags", s_fflags, 0);
        v_fflags_clr = 1;
        tick();
        v_fflags_clr = 0;
        chk("v_clr_alone", v_fflags, 0);
        chk("end_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
